// File: rtl/alu_pkg.sv
// Shared opcode encodings and default datapath width for the alu block.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 12;
  localparam int unsigned SEL_W     = 3;

  localparam logic [SEL_W-1:0] OP_ADD   = 3'b000;
  localparam logic [SEL_W-1:0] OP_SUB   = 3'b001;
  localparam logic [SEL_W-1:0] OP_MUL   = 3'b010;
  localparam logic [SEL_W-1:0] OP_SHL   = 3'b011;
  localparam logic [SEL_W-1:0] OP_SHR   = 3'b100;
  localparam logic [SEL_W-1:0] OP_INC   = 3'b101;
  localparam logic [SEL_W-1:0] OP_DEC   = 3'b110;
  localparam logic [SEL_W-1:0] OP_CONST = 3'b111;

endpackage

// File: rtl/alu_core.sv
// Combinational result mux: maps operands and opcode to a WIDTH-bit result.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] r_c
);

  // All arithmetic is evaluated in WIDTH-bit context, so carries, borrows
  // and upper product bits fall away naturally.
  always_comb begin
    r_c = '0;
    unique case (sel)
      OP_ADD:   r_c = a + b;
      OP_SUB:   r_c = a - b;
      OP_MUL:   r_c = a * b;
      OP_SHL:   r_c = {a[WIDTH-2:0], 1'b0};
      OP_SHR:   r_c = {1'b0, a[WIDTH-1:1]};
      OP_INC:   r_c = a + WIDTH'(1);
      OP_DEC:   r_c = a - WIDTH'(1);
      OP_CONST: r_c = '0;
      default:  r_c = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered ALU: one-cycle latency from operands/opcode to f, async active-low clear.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] f
);

  logic [WIDTH-1:0] r_c;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a   (a),
    .b   (b),
    .sel (sel),
    .r_c (r_c)
  );

  // Output register is the only state in the block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) f <= '0;
    else      f <= r_c;
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: directed vectors plus a random model-checked run.
module tb_alu;
  import alu_pkg::*;

  localparam int unsigned W = 12;

  typedef struct {
    logic [W-1:0] exp;
    string        name;
  } sb_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   sel;
  logic [W-1:0] f;

  sb_t          sbq[$];
  int           n_vec;
  int           n_err;
  logic [W-1:0] prev_exp;

  alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .sel (sel),
    .f   (f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%03h, expected 0x%03h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent reference: integer arithmetic reduced modulo 4096.
  function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [2:0] op);
    int unsigned xi, yi, res;
    xi = int'(x);
    yi = int'(y);
    case (op)
      3'd0: res = (xi + yi) % 4096;
      3'd1: res = (xi + 4096 - yi) % 4096;
      3'd2: res = (xi * yi) % 4096;
      3'd3: res = (xi * 2) % 4096;
      3'd4: res = xi / 2;
      3'd5: res = (xi + 1) % 4096;
      3'd6: res = (xi + 4095) % 4096;
      default: res = 0;
    endcase
    return W'(res);
  endfunction

  // Drive just after an edge, check hold before the next edge, queue the
  // result the next edge should load.
  task automatic apply(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [2:0] sv,
                       input logic [W-1:0] exp, input string name);
    sb_t e;
    @(posedge clk);
    #2;
    a   = av;
    b   = bv;
    sel = sv;
    e.exp  = exp;
    e.name = name;
    sbq.push_back(e);
    @(negedge clk);
    chk({name, "_hold"}, f, prev_exp);
    prev_exp = exp;
  endtask

  // Monitor: every loaded result is compared one step after the edge.
  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk(e.name, f, e.exp);
      end
    end
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic [2:0]   rs;
    string        onames[8];
    logic [W-1:0] sweep_exp[8];
    logic [W-1:0] bind_exp[8];
    int           guard;

    onames    = '{"add", "sub", "mul", "shl", "shr", "inc", "dec", "const"};
    sweep_exp = '{12'd30, 12'd10, 12'd200, 12'd40, 12'd10, 12'd21, 12'd19, 12'd0};
    bind_exp  = '{12'h000, 12'h000, 12'h000, 12'hB46, 12'h2D1, 12'h5A4, 12'h5A2, 12'h000};
    n_vec = 0;
    n_err = 0;
    prev_exp = '0;

    // Reset held across edges with live operands.
    rst = 1'b0;
    a   = 12'd20;
    b   = 12'd10;
    sel = OP_ADD;
    #1;
    chk("rst_async", f, 12'h000);
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold", f, 12'h000);
    end
    sel = OP_CONST;
    rst = 1'b1;

    // Opcode sweep, two cycles each.
    for (int i = 0; i < 8; i++) begin
      apply(12'd20, 12'd10, 3'(i), sweep_exp[i], {"sweep_", onames[i]});
      apply(12'd20, 12'd10, 3'(i), sweep_exp[i], {"sweep_", onames[i]});
    end

    // Wrap and truncation boundaries.
    apply(12'hFFF, 12'h001, OP_ADD, 12'h000, "wrap_add");
    apply(12'd10,  12'd20,  OP_SUB, 12'hFF6, "wrap_sub");
    apply(12'hFFF, 12'h123, OP_INC, 12'h000, "wrap_inc");
    apply(12'h000, 12'h456, OP_DEC, 12'hFFF, "wrap_dec");
    apply(12'h800, 12'h002, OP_MUL, 12'h000, "trunc_mul_800");
    apply(12'h0FF, 12'h0FF, OP_MUL, 12'hE01, "trunc_mul_0ff");
    apply(12'h800, 12'h000, OP_SHL, 12'h000, "trunc_shl");
    apply(12'h001, 12'h000, OP_SHR, 12'h000, "trunc_shr");

    // B independence with A fixed.
    for (int s = 3; s < 8; s++) begin
      for (int k = 0; k < 3; k++) begin
        apply(12'h5A3, W'($urandom), 3'(s), bind_exp[s], {"bind_", onames[s]});
      end
    end

    // Random traffic against the reference model.
    for (int k = 0; k < 200; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 3'($urandom_range(7, 0));
      apply(ra, rb, rs, model(ra, rb, rs), {"rand_", onames[rs]});
    end

    // Mid-stream reset with a nonzero result pending in f.
    apply(12'h123, 12'h111, OP_ADD, 12'h234, "pre_rst");
    @(posedge clk);
    #3;
    a   = 12'h7FF;
    sel = OP_INC;
    rst = 1'b0;
    #1;
    chk("rst_mid_async", f, 12'h000);
    @(negedge clk);
    chk("rst_mid_hold", f, 12'h000);
    sel = OP_CONST;
    rst = 1'b1;
    prev_exp = '0;
    apply(12'h7FF, 12'h000, OP_INC, 12'h800, "post_rst");

    // Drain the scoreboard with a bounded wait.
    guard = 0;
    while (sbq.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (sbq.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Registered 12-bit arithmetic/logic unit: combines two operands under a 3-bit opcode and presents the result on a clocked output register. It is a leaf datapath block driven directly by upstream operand and opcode registers, with no handshake. Results are modulo 2^WIDTH; no flags are produced.

## Interface
- WIDTH, default 12: operand and result width (all behaviour below stated for 12).
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-low reset.
- A  input  WIDTH  operand A (unsigned).
- B  input  WIDTH  operand B (unsigned).
- SEL  input  3  opcode.
- F  output  WIDTH  registered result.

## Operation
- Opcodes (result R computed combinationally, then truncated to low WIDTH bits):
  - 000 ADD: A + B; carry discarded.
  - 001 SUB: A − B; two's-complement wrap on borrow.
  - 010 MUL: low WIDTH bits of the 2·WIDTH-bit product A × B.
  - 011 SHL: A shifted left by 1; bit 0 = 0, MSB discarded.
  - 100 SHR: A logical shift right by 1; MSB = 0, LSB discarded.
  - 101 INC: A + 1; 0xFFF wraps to 0x000.
  - 110 DEC: A − 1; 0x000 wraps to 0xFFF.
  - 111 CONST: 0x000, independent of A and B.
- B is ignored for opcodes 011–111.
- All opcode values are defined; no X propagation from SEL when SEL is known.
- Arithmetic is unsigned; no overflow, carry, or zero indication is produced.

## Timing
- RST low: F forced to 0x000 immediately (asynchronous), held while RST low.
- RST deassertion takes effect at the next rising CLK edge; the first edge with RST high loads R.
- Each rising edge with RST high: F <= R(A, B, SEL) as sampled at that edge.
- Latency is 1 cycle from input change to F; F is stable between edges.
- Reset asserted mid-stream discards the pending result; no state other than F exists.
- Changing SEL between edges has no effect on F until the next edge.

## Structure
- Shared package alu_pkg: opcode localparams (OP_ADD=3'b000 … OP_CONST=3'b111) and default WIDTH.
- Sub-module alu_core: purely combinational, maps (A, B, SEL) to R; alu wraps it with the output register and reset.
- Multiplier is inferred; only the low WIDTH product bits are used.

## Test plan
- Reset: hold RST=0 with A=20, B=10, SEL=000 across edges -> F=0x000; assert RST mid-run with F≠0 -> F=0 without waiting for an edge.
- Opcode sweep, A=20, B=10, RST=1, 2 cycles per opcode -> ADD 30, SUB 10, MUL 200, SHL 40, SHR 10, INC 21, DEC 19, CONST 0, each appearing one edge after SEL changes.
- Wrap cases: ADD 0xFFF+0x001 -> 0x000; SUB 10−20 -> 0xFF6; INC 0xFFF -> 0x000; DEC 0x000 -> 0xFFF.
- Truncation: MUL 0x800×0x002 -> 0x000; MUL 0x0FF×0x0FF -> 0xE01; SHL 0x800 -> 0x000; SHR 0x001 -> 0x000.
- B-independence: for SEL=011..111, vary B randomly with A fixed -> F unchanged.
- Latency: change A, B, SEL just after an edge -> F keeps its previous value until the next rising edge, then updates; random A/B/SEL compared against a reference model each cycle.
